// File: rtl/alu_sequencer.sv
// Command front-end for an 8-bit registered accumulator ALU: queues operations, issues one
// at a time, captures each result and blocks divide-by-zero.
module alu_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic [3:0]               alu_sel,
  input  logic [7:0]               alu_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_data,
  output logic                     res_div0,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] Full = LvlW'(DEPTH);

  localparam logic [3:0] OpClr = 4'b0000;
  localparam logic [3:0] OpDiv = 4'b0011;
  localparam logic [3:0] OpNop = 4'b0100;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StExec,
    StCapt,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   fifo_level_q, fifo_level_d;
  logic [7:0]        alu_a_q, alu_a_d;
  logic [7:0]        alu_b_q, alu_b_d;
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic              dz_q, dz_d;
  logic              res_valid_q, res_valid_d;
  logic [7:0]        res_data_q, res_data_d;
  logic              res_div0_q, res_div0_d;

  // Entry layout: {op, a, b}
  logic [19:0]       mem_q [DEPTH];
  logic [19:0]       head;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  assign in_ready   = (fifo_level_q < Full);
  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_level_q == '0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_level_d = fifo_level_q;
    dz_d         = dz_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_div0_d   = res_div0_q;
    pop          = 1'b0;
    // The ALU updates on every edge, so anything other than an issued op must be Acc + 0.
    alu_sel_d    = OpNop;
    alu_a_d      = 8'h00;
    alu_b_d      = 8'h00;

    case (state_q)
      StInit: state_d = StIdle;
      StIdle: begin
        if (!fifo_empty) pop = 1'b1;
      end
      StExec: state_d = StCapt;
      StCapt: begin
        res_data_d  = dz_q ? 8'hFF : alu_result;
        res_div0_d  = dz_q;
        res_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      state_d  = StExec;
      dz_d     = (head[19:16] == OpDiv) && (head[7:0] == 8'h00);
      // A blocked divide keeps the NOP issued so the accumulator is left untouched.
      if (!dz_d) begin
        alu_sel_d = head[19:16];
        alu_a_d   = head[15:8];
        alu_b_d   = head[7:0];
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   fifo_level_d = fifo_level_q + LvlW'(1);
      2'b01:   fifo_level_d = fifo_level_q - LvlW'(1);
      default: fifo_level_d = fifo_level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInit;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_level_q <= '0;
      alu_sel_q    <= OpClr;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      dz_q         <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= 8'h00;
      res_div0_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_level_q <= fifo_level_d;
      alu_sel_q    <= alu_sel_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      dz_q         <= dz_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_div0_q   <= res_div0_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_op, in_a, in_b};
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_div0   = res_div0_q;
  assign fifo_level = fifo_level_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command front-end that sits directly upstream of the 8-bit registered accumulator ALU and drives its A, B and ALU_Sel pins. It accepts operations over a valid/ready interface into a small FIFO and issues them one at a time. It then captures the ALU result and presents it on a valid/ready result port. It also guarantees a defined accumulator after reset, preserves the accumulator while idle, and blocks divide-by-zero.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  command present
in_ready  output  1  FIFO can accept (level < DEPTH)
in_op  input  4  ALU opcode, same encoding as ALU_Sel
in_a  input  8  operand A
in_b  input  8  operand B
alu_a  output  8  registered, to ALU A
alu_b  output  8  registered, to ALU B
alu_sel  output  4  registered, to ALU ALU_Sel
alu_result  input  8  ALU_out from ALU
res_valid  output  1  result held
res_ready  input  1  consumer accepts result
res_data  output  8  captured result
res_div0  output  1  result was a blocked divide-by-zero
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0):
  - State = INIT; FIFO empty; fifo_level=0.
  - alu_sel=4'b0000, alu_a=0, alu_b=0 (CLR), so the ALU's first post-reset edge loads accumulator = 0.
  - res_valid=0, res_data=0, res_div0=0.
- NOP: alu_sel=4'b0100, alu_a=0, alu_b=0 (Acc = Acc + 0). The ALU updates every edge with no hold, so NOP is driven in every state except EXEC.
- FIFO:
  - Push on in_valid && in_ready.
  - in_ready = (level < DEPTH) from current level only; a same-cycle pop does not free a slot.
  - Pop occurs only on IDLE/HOLD -> EXEC. Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo DEPTH; order is strictly FIFO.
- States:
  - INIT: one cycle, driving CLR. Next edge -> IDLE and register NOP.
  - IDLE: drive NOP. If FIFO non-empty, pop the head and go to EXEC.
    - Normal op: register the head into alu_a/alu_b/alu_sel.
    - Div-by-zero (op 4'b0011 with b==0): keep NOP registered and set internal flag dz=1.
  - EXEC: the ALU computes at the next edge. On that edge register NOP and go to CAPT.
  - CAPT: alu_result holds the op result. On the next edge:
    - res_data <= dz ? 8'hFF : alu_result; res_div0 <= dz; res_valid <= 1.
    - Go to HOLD.
  - HOLD: res_valid=1; res_data and res_div0 stable until accepted.
    - res_ready=1 with FIFO non-empty: pop and go directly to EXEC (same pop rules as IDLE); res_valid=0 next cycle.
    - res_ready=1 with FIFO empty: go to IDLE; res_valid=0.
    - res_ready=0: stay in HOLD.
- Latency:
  - Push edge to res_valid high: 3 cycles when the sequencer is idle.
  - Back-to-back throughput: one result per 3 cycles with res_ready held high.
- One op in flight at most. The accumulator ops (0100/0101/0110) therefore always see the previous op's result.
- Blocked divide-by-zero leaves the accumulator unchanged.
- Reset mid-operation: everything returns to reset values immediately, including discarding FIFO contents and any pending result. INIT re-clears the accumulator after release.
- res_data is 8-bit; overflow wraps as the ALU produces it and is not flagged.

Test Plan:
1. Reset release, push op=0000 a=3 b=5 with res_ready=1 -> res_valid high 3 cycles after the push edge, res_data=8'h08, res_div0=0, res_valid for exactly 1 cycle.
2. Accumulate: push 0100 a=7, wait 10 idle cycles, push 0100 a=5, then 0101 a=3 -> results 7, 12, 36. Accumulator is preserved across idle gaps.
3. Backpressure, DEPTH=4: res_ready=0, push six 0000 ops with a=i, b=1:
   - in_ready low after five accepts (one in HOLD, four in FIFO); fifo_level=4.
   - Raise res_ready -> results 1..5 in order, each held until accepted.
4. Divide-by-zero: push 0100 a=20, then 0011 a=9 b=0, then 0100 a=1 -> results 20, then FF with res_div0=1, then 21. alu_sel is never 0011 during the sequence.
5. Op coverage: 0111 a=8'h81 -> 8'h03; 1000 a=8'h81 -> 8'hC0; 1110 a=5 b=3 -> 8'hFF; 1111 a=5 b=3 -> 8'h00; 0010 a=16 b=17 -> 8'h10 (wrap).
6. Reset mid-op: pull rst_n low during EXEC with 2 ops queued -> immediately res_valid=0, fifo_level=0, alu_sel=0000. After release, push 0100 a=2 -> result 2.
